// File: rtl/up_counter.sv
// up_counter: parameterised free-running binary up-counter with synchronous
// clear and count enable. Used as the column/row position counter of the VGA
// timing generator (WIDTH=11).
//
// Parameters:
//   WIDTH     - counter/output width in bits, legal range 1..32 (default 8)
//
// Ports:
//   clock     - in,  1     : rising-edge clock
//   reset     - in,  1     : synchronous active-high clear (wins over enable)
//   enable    - in,  1     : count enable, +1 per clock when high
//   oResult   - out, WIDTH : current count, driven straight from the register
//   oTerminal - out, 1     : carry out for cascading, only when the macro
//                            UPCOUNTER_TC_EN is defined; combinational,
//                            high in the cycle before a natural wrap to 0
//
// Build option: define UPCOUNTER_TC_EN to add oTerminal. With the macro
// undefined the port and its logic do not exist; counting is identical.

module up_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
`ifdef UPCOUNTER_TC_EN
  output logic             oTerminal,
`endif
  output logic [WIDTH-1:0] oResult
);

  // Declaration initialiser gives a known power-up value for simulation and
  // FPGA configuration; a single reset edge is still all that is required.
  logic [WIDTH-1:0] r_count = '0;

  // Count register: reset has priority, so an X on enable during reset is
  // never sampled into the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign oResult = r_count;

`ifdef UPCOUNTER_TC_EN
  // Terminal count: the increment about to carry out of the MSB.
  logic w_at_max;
  assign w_at_max  = (r_count == {WIDTH{1'b1}});
  assign oTerminal = enable & ~reset & w_at_max;
`endif

endmodule

// File: tb/tb_up_counter.sv
// Directed self-checking bench for up_counter: a WIDTH=11 instance covers
// reset, counting, hold, wrap, reset/enable collision and the VGA column/row
// usage patterns; a WIDTH=1 instance covers the single-bit toggle case.

module tb_up_counter;

  localparam int unsigned W11 = 11;
  localparam int unsigned W1  = 1;

  logic           clock;
  logic           reset;
  logic           enable;
  logic [W11-1:0] result;
  logic           reset1;
  logic           enable1;
  logic [W1-1:0]  result1;
`ifdef UPCOUNTER_TC_EN
  logic           terminal;
  logic           terminal1;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  up_counter #(.WIDTH(W11)) u_dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
`ifdef UPCOUNTER_TC_EN
    .oTerminal (terminal),
`endif
    .oResult   (result)
  );

  up_counter #(.WIDTH(W1)) u_dut1 (
    .clock     (clock),
    .reset     (reset1),
    .enable    (enable1),
`ifdef UPCOUNTER_TC_EN
    .oTerminal (terminal1),
`endif
    .oResult   (result1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge, then move 1 time unit past it for sampling/driving.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b0;
    step();
    n_vec++;
    if (result !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_first: got %0d expected 0", result);
    end
    step();
    n_vec++;
    if (result !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_second: got %0d expected 0", result);
    end
    // X on enable while in reset must not leak into the count.
    enable = 1'bx;
    step();
    n_vec++;
    if (result !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_x_enable: got %0d expected 0", result);
    end
`ifdef UPCOUNTER_TC_EN
    n_vec++;
    if (terminal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_terminal: got %0b expected 0", terminal);
    end
`endif
    enable = 1'b0;
  endtask

  task automatic test_count();
    reset  = 1'b0;
    enable = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      n_vec++;
      if (result !== W11'(i)) begin
        n_fail++;
        $display("FAIL count_%0d: got %0d expected %0d", i, result, i);
      end
    end
  endtask

  task automatic test_hold();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++;
      if (result !== 11'd5) begin
        n_fail++;
        $display("FAIL hold_%0d: got %0d expected 5", i, result);
      end
    end
    enable = 1'b1;
    step();
    n_vec++;
    if (result !== 11'd6) begin
      n_fail++;
      $display("FAIL hold_resume: got %0d expected 6", result);
    end
    enable = 1'b0;
    reset  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_vec++;
      if (result !== 11'd0) begin
        n_fail++;
        $display("FAIL hold_reset_%0d: got %0d expected 0", i, result);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_wrap();
    enable = 1'b1;
    for (int i = 0; i < 2046; i++) step();
    n_vec++;
    if (result !== 11'd2046) begin
      n_fail++;
      $display("FAIL wrap_2046: got %0d expected 2046", result);
    end
`ifdef UPCOUNTER_TC_EN
    n_vec++;
    if (terminal !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_tc_2046: got %0b expected 0", terminal);
    end
`endif
    step();
    n_vec++;
    if (result !== 11'd2047) begin
      n_fail++;
      $display("FAIL wrap_2047: got %0d expected 2047", result);
    end
`ifdef UPCOUNTER_TC_EN
    n_vec++;
    if (terminal !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_tc_2047: got %0b expected 1", terminal);
    end
    enable = 1'b0;
    #1;
    n_vec++;
    if (terminal !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_tc_disabled: got %0b expected 0", terminal);
    end
    enable = 1'b1;
    reset  = 1'b1;
    #1;
    n_vec++;
    if (terminal !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_tc_reset: got %0b expected 0", terminal);
    end
    reset = 1'b0;
    #1;
`endif
    step();
    n_vec++;
    if (result !== 11'd0) begin
      n_fail++;
      $display("FAIL wrap_zero: got %0d expected 0", result);
    end
`ifdef UPCOUNTER_TC_EN
    n_vec++;
    if (terminal !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_tc_zero: got %0b expected 0", terminal);
    end
`endif
  endtask

  task automatic test_reset_enable();
    enable = 1'b1;
    reset  = 1'b0;
    for (int i = 0; i < 300; i++) step();
    n_vec++;
    if (result !== 11'd300) begin
      n_fail++;
      $display("FAIL collide_300: got %0d expected 300", result);
    end
    reset = 1'b1;
    step();
    n_vec++;
    if (result !== 11'd0) begin
      n_fail++;
      $display("FAIL collide_reset: got %0d expected 0", result);
    end
    reset = 1'b0;
    step();
    n_vec++;
    if (result !== 11'd1) begin
      n_fail++;
      $display("FAIL collide_release: got %0d expected 1", result);
    end
  endtask

  // Column use: clear requested once the count has passed 799, so the count
  // runs 0..800 and repeats every 801 clocks.
  task automatic test_column();
    int exp_cnt;
    int max_seen;
    int last_zero;
    int period;
    reset  = 1'b1;
    enable = 1'b1;
    step();
    reset     = 1'b0;
    exp_cnt   = 0;
    max_seen  = 0;
    last_zero = 0;
    period    = 0;
    for (int c = 1; c <= 3 * 801; c++) begin
      reset = (exp_cnt > 799);
      step();
      exp_cnt = reset ? 0 : exp_cnt + 1;
      n_vec++;
      if (result !== W11'(exp_cnt)) begin
        n_fail++;
        $display("FAIL column_cycle_%0d: got %0d expected %0d", c, result, exp_cnt);
      end
      if (int'(result) > max_seen) max_seen = int'(result);
      if (result == 11'd0) begin
        period    = c - last_zero;
        last_zero = c;
      end
    end
    reset = 1'b0;
    n_vec++;
    if (max_seen != 800) begin
      n_fail++;
      $display("FAIL column_max: got %0d expected 800", max_seen);
    end
    n_vec++;
    if (period != 801) begin
      n_fail++;
      $display("FAIL column_period: got %0d expected 801", period);
    end
  endtask

  // Row use: a one-cycle enable pulse every 801 clocks advances by one.
  task automatic test_row();
    reset  = 1'b1;
    enable = 1'b0;
    step();
    reset = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      enable = 1'b1;
      step();
      enable = 1'b0;
      n_vec++;
      if (result !== W11'(p)) begin
        n_fail++;
        $display("FAIL row_pulse_%0d: got %0d expected %0d", p, result, p);
      end
      for (int i = 0; i < 800; i++) step();
      n_vec++;
      if (result !== W11'(p)) begin
        n_fail++;
        $display("FAIL row_gap_%0d: got %0d expected %0d", p, result, p);
      end
    end
  endtask

  task automatic test_width1();
    logic [W1-1:0] exp_bit;
    reset1  = 1'b1;
    enable1 = 1'b1;
    step();
    n_vec++;
    if (result1 !== 1'b0) begin
      n_fail++;
      $display("FAIL w1_reset: got %0b expected 0", result1);
    end
    reset1  = 1'b0;
    exp_bit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_bit = ~exp_bit;
      n_vec++;
      if (result1 !== exp_bit) begin
        n_fail++;
        $display("FAIL w1_toggle_%0d: got %0b expected %0b", i, result1, exp_bit);
      end
`ifdef UPCOUNTER_TC_EN
      n_vec++;
      if (terminal1 !== exp_bit) begin
        n_fail++;
        $display("FAIL w1_tc_%0d: got %0b expected %0b", i, terminal1, exp_bit);
      end
`endif
    end
    enable1 = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    reset1  = 1'b1;
    enable1 = 1'b0;
    #1;
    test_reset();
    test_count();
    test_hold();
    test_wrap();
    test_reset_enable();
    test_column();
    test_row();
    test_width1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
